psum_ofifo: RTL and testbench
=============================

# psum_ofifo

Output-side receiver for the MAC array's per-column partial-sum stream. Each column drives its psum word with an independent write strobe, and the strobes are skewed by one cycle per column because `inst` ripples down the array. This block buffers each column in its own FIFO and re-aligns the data. It presents a full row (one psum per column) to the downstream SFU/accumulator only when every column holds at least one word, and it pops all columns together.

## Interface
Parameters:
- `col`, 8: number of MAC columns / FIFO lanes.
- `bw_psum`, 22: psum width per column (2*bw+6 with bw=8).
- `depth`, 16: entries per lane. Must be a power of two and ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in`  in  col*bw_psum  psums from the array; lane i is bits [bw_psum*(i+1)-1 : bw_psum*i].
- `wr`  in  col  per-lane write strobe (the array's `fifo_wr`); bit i qualifies lane i of `in`.
- `rd`  in  1  pop one aligned row; honored only when `o_valid`=1.
- `out`  out  col*bw_psum  head row, same lane packing as `in`; forced to 0 when `o_valid`=0.
- `o_valid`  out  1  every lane holds ≥1 entry.
- `o_full`  out  1  at least one lane holds `depth` entries.
- `rows`  out  log2(depth)+1  number of complete rows available (minimum lane occupancy).
- `overflow`  out  1  sticky. Set when a write is dropped at a full lane; cleared only by `reset`.

## Operation
- Per lane: storage array [depth][bw_psum], write pointer, read pointer, and an occupancy count of log2(depth)+1 bits. Pointers wrap modulo `depth`.
- Write: lane i stores `in` lane i at its write pointer and advances the pointer when `wr[i]`=1, and either count_i<`depth` or a row pop happens in the same cycle.
- Dropped write: `wr[i]`=1, count_i=`depth`, and no pop in that cycle. The data is discarded, pointer and count stay unchanged, and `overflow`←1.
- Pop: when `rd`=1 and `o_valid`=1, every lane's read pointer advances by 1 and every count decrements by 1. `rd` with `o_valid`=0 has no effect and is not an error.
- Simultaneous push and pop on a lane: both take effect, so the count is unchanged. At count=`depth` this is legal and drops nothing.
- Lanes fill independently. Skewed strobes (lane i written k cycles after lane i-1) and lanes running ahead by several rows are both normal. Alignment is by order of arrival per lane, not by cycle.
- `out` is read first-word-fall-through from each lane's read pointer. Storage is not reset.
- `o_valid` = AND over lanes of (count_i≠0). `o_full` = OR over lanes of (count_i==`depth`). `rows` = minimum count_i. All three are derived from registered counts only.
- No data width conversion: psums pass bit-exact with no sign extension.

## Timing
- Reset: all pointers and counts go to 0. `o_valid`=0, `o_full`=0, `rows`=0, `overflow`=0, `out`=0 from the first edge with `reset`=1. A `wr` or `rd` during reset is ignored.
- Reset mid-operation: all buffered rows are discarded on that edge.
- Write latency: a word written at edge t is visible in counts and flags after edge t, and appears on `out` in the same cycle if it completes the head row.
- Pop: `out` shows the next row in the cycle after the popping edge. Sustained `rd`=1 with data available drains one row per cycle.
- Full-rate operation: one write per lane and one pop per cycle can be sustained indefinitely without loss.
- `o_full` is a status flag only and has no effect on `wr`. The array side must stall on `o_full`, or `overflow` records the loss.

## Test plan
- After reset, write lane i with value 100+i at cycle 1+i (staircase skew, `col`=8). `o_valid` must stay 0 through cycle 8, rise after the lane-7 write, `rows`=1, and `out` lanes must equal 100..107. Then `rd`=1 for one cycle, after which `o_valid`=0 and `rows`=0.
- Write 16 rows to all lanes with value row*10+lane. `o_full`=1 and `rows`=16. Then write row 16 without `rd`: `overflow`=1, counts stay 16, and draining 16 pops returns rows 0..15 in order.
- At full, assert `wr`=all-ones and `rd`=1 together for 20 cycles. Required: no overflow, `rows` stays 16, and the pop sequence is contiguous, exercising pointer wrap.
- Fill lanes 0–6 with 3 entries each and leave lane 7 empty. `o_valid`=0, `rows`=0, and `rd`=1 changes nothing. Then write lane 7 once: `rows`=1.
- Load 5 rows, pulse `reset` for one cycle mid-stream while `wr` and `rd` are active. Counts are 0, `o_valid`=0, and `overflow`=0. The next written row reads back correctly.

Source files
------------

// File: rtl/psum_ofifo.sv
// Per-column psum FIFOs that re-align skewed column streams into whole rows.
// A row is presented only when every lane has a word, and all lanes pop together.
module psum_ofifo #(
    parameter int col     = 8,
    parameter int bw_psum = 22,
    parameter int depth   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [col*bw_psum-1:0]      in,
    input  logic [col-1:0]              wr,
    input  logic                        rd,
    output logic [col*bw_psum-1:0]      out,
    output logic                        o_valid,
    output logic                        o_full,
    output logic [$clog2(depth):0]      rows,
    output logic                        overflow
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    logic [bw_psum-1:0] mem [col][depth];
    logic [aw-1:0]      wptr [col];
    logic [aw-1:0]      rptr [col];
    logic [cw-1:0]      cnt  [col];

    logic           pop;
    logic [col-1:0] push;
    logic [col-1:0] drop;

    // A full lane still accepts a write when the row pop frees a slot that same edge.
    always_comb begin
        pop  = rd && o_valid;
        push = '0;
        drop = '0;
        for (int i = 0; i < col; i++) begin
            push[i] = wr[i] && ((cnt[i] != full_cnt) || pop);
            drop[i] = wr[i] && (cnt[i] == full_cnt) && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + 1'b1;
                if (pop)     rptr[i] <= rptr[i] + 1'b1;
                if (push[i] && !pop)      cnt[i] <= cnt[i] + 1'b1;
                else if (!push[i] && pop) cnt[i] <= cnt[i] - 1'b1;
            end
            if (|drop) overflow <= 1'b1;
        end
    end

    // Storage carries no reset; pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (!reset && push[i]) mem[i][wptr[i]] <= in[i*bw_psum +: bw_psum];
        end
    end

    always_comb begin
        o_valid = 1'b1;
        o_full  = 1'b0;
        rows    = cnt[0];
        for (int i = 0; i < col; i++) begin
            if (cnt[i] == '0)      o_valid = 1'b0;
            if (cnt[i] == full_cnt) o_full = 1'b1;
            if (cnt[i] < rows)     rows    = cnt[i];
        end
    end

    always_comb begin
        out = '0;
        if (o_valid) begin
            for (int i = 0; i < col; i++) out[i*bw_psum +: bw_psum] = mem[i][rptr[i]];
        end
    end
endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: per-lane queue reference model, a staircase vector table,
// hand-written full/overflow/reset sequences, and a randomized soak.
module tb_psum_ofifo;
    localparam int COL = 8;
    localparam int BW = 22;
    localparam int DEPTH = 16;
    localparam int CW = 5;
    localparam int VW = COL * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [VW-1:0] din = '0;
    logic [COL-1:0] wr = '0;
    logic          rd = 1'b0;
    logic [VW-1:0] out;
    logic          o_valid, o_full, overflow;
    logic [CW-1:0] rows;

    int total = 0;
    int bad = 0;

    logic [BW-1:0] mq [COL][$];
    logic          m_ovf = 1'b0;

    psum_ofifo #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd),
        .out(out), .o_valid(o_valid), .o_full(o_full), .rows(rows), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] row_vec(input int r);
        logic [VW-1:0] v;
        v = '0;
        for (int j = 0; j < COL; j++) v[j*BW +: BW] = BW'(r * 10 + j);
        return v;
    endfunction

    task automatic cmp(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each lane is an order-of-arrival queue; a row exists when all lanes are non-empty.
    task automatic model_update(input logic [COL-1:0] w, input logic [VW-1:0] d,
                                input logic r, input logic rs);
        bit all_ne;
        if (rs) begin
            for (int j = 0; j < COL; j++) mq[j].delete();
            m_ovf = 1'b0;
            return;
        end
        all_ne = 1;
        for (int j = 0; j < COL; j++) if (mq[j].size() == 0) all_ne = 0;
        for (int j = 0; j < COL; j++) begin
            if (w[j]) begin
                if (mq[j].size() < DEPTH || (r && all_ne)) mq[j].push_back(d[j*BW +: BW]);
                else m_ovf = 1'b1;
            end
        end
        if (r && all_ne) for (int j = 0; j < COL; j++) void'(mq[j].pop_front());
    endtask

    task automatic check_model();
        int mn;
        bit ev, ef;
        logic [VW-1:0] eo;
        mn = DEPTH;
        ef = 0;
        eo = '0;
        for (int j = 0; j < COL; j++) begin
            if (mq[j].size() < mn) mn = mq[j].size();
            if (mq[j].size() == DEPTH) ef = 1;
        end
        ev = (mn != 0);
        if (ev) for (int j = 0; j < COL; j++) eo[j*BW +: BW] = mq[j][0];
        cmp("o_valid", VW'(o_valid), VW'(ev));
        cmp("o_full", VW'(o_full), VW'(ef));
        cmp("rows", VW'(rows), VW'(mn));
        cmp("overflow", VW'(overflow), VW'(m_ovf));
        cmp("out", out, eo);
    endtask

    task automatic step(input logic [COL-1:0] w, input logic [VW-1:0] d,
                        input logic r, input logic rs);
        wr = w; din = d; rd = r; reset = rs;
        @(posedge clk);
        model_update(w, d, r, rs);
        @(negedge clk);
        wr = '0; rd = 1'b0; reset = 1'b0;
        check_model();
    endtask

    typedef struct {
        logic [COL-1:0] w;
        logic           r;
        logic           ev;
        logic [CW-1:0]  er;
    } vec_t;
    vec_t tbl [9];

    initial begin
        for (int i = 0; i < COL; i++) tbl[i] = '{w: COL'(1 << i), r: 1'b0, ev: (i == COL - 1), er: CW'(i == COL - 1)};
        tbl[8] = '{w: '0, r: 1'b1, ev: 1'b0, er: '0};

        // Reset state
        @(negedge clk);
        step('0, '0, 1'b0, 1'b1);
        cmp("reset_valid", VW'(o_valid), '0);
        cmp("reset_rows", VW'(rows), '0);
        cmp("reset_out", out, '0);

        // Staircase skew: lane i written at cycle 1+i with 100+i
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].w, row_vec(10), tbl[k].r, 1'b0);
            cmp("stair_valid", VW'(o_valid), VW'(tbl[k].ev));
            cmp("stair_rows", VW'(rows), VW'(tbl[k].er));
            if (k == COL - 1) cmp("stair_out", out, row_vec(10));
        end

        // Fill to depth, then a dropped write, then drain in order
        for (int r = 0; r < DEPTH; r++) step('1, row_vec(r), 1'b0, 1'b0);
        cmp("fill_full", VW'(o_full), VW'(1));
        cmp("fill_rows", VW'(rows), VW'(DEPTH));
        cmp("fill_ovf", VW'(overflow), '0);
        step('1, row_vec(DEPTH), 1'b0, 1'b0);
        cmp("drop_ovf", VW'(overflow), VW'(1));
        cmp("drop_rows", VW'(rows), VW'(DEPTH));
        for (int r = 0; r < DEPTH; r++) begin
            cmp("drain_out", out, row_vec(r));
            step('0, '0, 1'b1, 1'b0);
        end
        cmp("drain_valid", VW'(o_valid), '0);

        // Reset mid-stream with wr and rd active; sticky overflow must clear
        for (int r = 0; r < 5; r++) step('1, row_vec(r), 1'b0, 1'b0);
        step('1, row_vec(9), 1'b1, 1'b1);
        cmp("midrst_rows", VW'(rows), '0);
        cmp("midrst_valid", VW'(o_valid), '0);
        cmp("midrst_ovf", VW'(overflow), '0);
        step('1, row_vec(7), 1'b0, 1'b0);
        cmp("midrst_out", out, row_vec(7));
        step('0, '0, 1'b1, 1'b0);

        // Full-rate push+pop at full: pointer wrap, no loss
        for (int r = 0; r < DEPTH; r++) step('1, row_vec(r), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step('1, row_vec(DEPTH + k), 1'b1, 1'b0);
            cmp("wrap_rows", VW'(rows), VW'(DEPTH));
            cmp("wrap_out", out, row_vec(k + 1));
        end
        cmp("wrap_ovf", VW'(overflow), '0);

        // Lane 7 empty: no row, rd ignored, then one write completes a row
        step('0, '0, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) step(8'h7f, row_vec(r), 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        cmp("lane7_valid", VW'(o_valid), '0);
        cmp("lane7_rows", VW'(rows), '0);
        step(8'h80, row_vec(0), 1'b0, 1'b0);
        cmp("lane7_rows1", VW'(rows), VW'(1));

        // Randomized soak against the queue model
        for (int k = 0; k < 3000; k++) begin
            logic [VW-1:0] d;
            logic [COL-1:0] w;
            for (int j = 0; j < COL; j++) d[j*BW +: BW] = BW'($urandom);
            w = COL'($urandom);
            if ($urandom_range(0, 3) == 0) w = '1;
            step(w, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
